clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Receiving end of the divided-clock path: samples a slow toggling clock signal (`clk_in`) in the fast `clk` domain.
- Emits one-cycle tick enables for downstream counters (seconds/minutes logic), measures the half-period and reports lock and loss status.
- Lets clock logic run on `clk` with enables instead of on derived clocks.

Parameters:
- FROM_HZ, 10, frequency of `clk` in Hz.
- TO_HZ, 1, expected frequency of `clk_in` in Hz (FROM_HZ > TO_HZ).
- SYNC_STAGES, 2, synchroniser flops on `clk_in` (>= 2).
- LOCK_COUNT, 4, consecutive in-tolerance half-periods required to lock.

Ports:
- clk  input  1  fast system clock.
- rst  input  1  asynchronous, active-high reset.
- clk_in  input  1  slow toggling clock, asynchronous to `clk`.
- tick  output  1  one-cycle pulse per detected rising edge of `clk_in`.
- half_period  output  32  `clk` cycles between the last two detected edges.
- locked  output  1  `clk_in` half-period within tolerance.
- lost  output  1  no edge seen within the timeout window.

Behaviour:
- Constants:
  - EXP_HALF = FROM_HZ/TO_HZ + 1, the matching divider toggles every threshold+1 cycles.
  - TOL = EXP_HALF/4, integer division.
  - TIMEOUT = 2*EXP_HALF.
- Reset (async, any time including mid-lock):
  - All sync flops and the edge-detect register go to 0.
  - Cycle counter, good count, tick, half_period, locked and lost go to 0.
  - State goes to IDLE.
- Sync and edge detect:
  - The last sync stage is compared with its registered copy; edge = values differ, either polarity.
  - `tick` is registered and rises-only. A `clk_in` rise captured at posedge n gives `tick` high for exactly the cycle starting at posedge n+SYNC_STAGES.
- Cycle counter:
  - Increments every cycle and saturates at 2^32-1.
  - On an edge, `half_period` latches counter+1 and the counter clears to 0.
  - Exception: the first edge after reset or after LOST only clears the counter; `half_period` is not updated.
- In tolerance means EXP_HALF-TOL <= measured <= EXP_HALF+TOL, unsigned 32-bit compare.
- State machine:
  - IDLE: on edge -> ACQUIRE with good count = 0. Counter reaching TIMEOUT -> LOST.
  - ACQUIRE: on an in-tolerance edge, good count +1; when it reaches LOCK_COUNT -> LOCKED. On an out-of-tolerance edge, good count = 0. Timeout -> LOST.
  - LOCKED: an out-of-tolerance edge -> ACQUIRE with good count 0. Timeout -> LOST.
  - LOST: on edge -> ACQUIRE with good count 0. This edge does not update `half_period`.
- Outputs:
  - `locked` is 1 only in LOCKED; `lost` is 1 only in LOST.
  - Both are registered and change in the same cycle as the state.
- Simultaneous edge and counter == TIMEOUT: the edge wins and no LOST transition occurs.
- `tick` fires in every state, including IDLE and LOST.

Optional Feature:
- Macro: CLOCK_MONITOR_DEGLITCH_EN.
- Defined: the synchronised level is accepted only after it has been stable for 3 consecutive `clk` cycles. Shorter pulses are ignored. Tick latency grows by 2 cycles.
- Not defined: every change of the last sync stage counts as an edge.

Decomposition:
- Shared package `clock_pkg`:
  - state enum (IDLE, ACQUIRE, LOCKED, LOST);
  - 32-bit count typedef;
  - helper functions computing EXP_HALF, TOL and TIMEOUT from FROM_HZ/TO_HZ.
- One sub-module, `sync_edge_detect`:
  - parameterised synchroniser, plus the optional deglitch filter, plus edge register;
  - outputs `rise` and `any_edge` pulses.
- Counter and state machine stay in `clock_monitor`.

Test Plan:
Shared settings: FROM_HZ=10, TO_HZ=1 (EXP_HALF=11, TOL=2, TIMEOUT=22), LOCK_COUNT=4, SYNC_STAGES=2.
1. Hold `rst`=1, toggle `clk_in` -> `tick`, `half_period`, `locked` and `lost` all stay 0. Release -> still 0 until the first edge.
2. Toggle `clk_in` every 11 cycles -> `tick` 2 cycles after each captured rise; `half_period`=11 from the 2nd edge; `locked`=1 after the 5th edge.
3. While locked, stretch one half-period to 14 -> `half_period`=14 and `locked` drops on that edge; relock after 4 further 11-cycle halves.
4. Toggle every 9 cycles, then every 13 -> lock is achieved in both cases (tolerance boundaries inclusive). Every 8 cycles -> never locks.
5. Stop `clk_in` after an edge -> `lost`=1 and `locked`=0 when the counter reaches 22. Next edge -> `lost`=0, state ACQUIRE, `half_period` unchanged.
6. Edge detected in the same cycle the counter hits 22 -> no `lost`. Assert `rst` mid-LOCKED -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and derived constants for the clock monitor.
// Provides the monitor state enum, count type and EXP_HALF/TOL/TIMEOUT helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        LOST
    } state_t;

    typedef logic [31:0] count_t;

    localparam count_t COUNT_MAX = '1;

    // The matching divider toggles every threshold+1 cycles.
    function automatic count_t exp_half(input int unsigned from_hz,
                                        input int unsigned to_hz);
        return count_t'(from_hz / to_hz + 32'd1);
    endfunction

    function automatic count_t tol(input int unsigned from_hz,
                                   input int unsigned to_hz);
        return exp_half(from_hz, to_hz) / 32'd4;
    endfunction

    function automatic count_t timeout(input int unsigned from_hz,
                                       input int unsigned to_hz);
        return exp_half(from_hz, to_hz) << 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser, optional deglitch filter (CLOCK_MONITOR_DEGLITCH_EN) and edge register.
// Ports: clk, rst (async high), clk_in (async) -> rise, any_edge (combinational pulses).
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    output logic rise,
    output logic any_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
        end
    end

`ifdef CLOCK_MONITOR_DEGLITCH_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
        end
    end

    // Accept a new level only once it has been seen on three
    // consecutive cycles; otherwise hold the accepted level.
    always_comb begin
        level = level_q;
        if (sync_q[SYNC_STAGES-1] == hist_q[0] && hist_q[0] == hist_q[1]) begin
            level = sync_q[SYNC_STAGES-1];
        end
    end
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise     = level & ~level_q;
    assign any_edge = level ^ level_q;

endmodule

// File: rtl/clock_monitor.sv
// Samples a slow clock in the clk domain, emits rise ticks, measures the half-period, tracks lock/loss.
// Ports: clk, rst (async high), clk_in -> tick, half_period[31:0], locked, lost. Option: CLOCK_MONITOR_DEGLITCH_EN.
module clock_monitor
    import clock_pkg::*;
#(
    parameter int unsigned FROM_HZ     = 10,
    parameter int unsigned TO_HZ       = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_in,
    output logic        tick,
    output logic [31:0] half_period,
    output logic        locked,
    output logic        lost
);

    localparam count_t EXP_HALF = exp_half(FROM_HZ, TO_HZ);
    localparam count_t TOL      = tol(FROM_HZ, TO_HZ);
    localparam count_t TIMEOUT  = timeout(FROM_HZ, TO_HZ);
    localparam count_t LO       = EXP_HALF - TOL;
    localparam count_t HI       = EXP_HALF + TOL;
    localparam count_t LOCK_CNT = count_t'(LOCK_COUNT);

    state_t state_q, state_d;
    count_t cnt_q;
    count_t good_q, good_d;
    count_t measured;
    logic   rise, any_edge;
    logic   first_edge, in_tol, timed_out;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (clk_in),
        .rise     (rise),
        .any_edge (any_edge)
    );

    assign measured   = cnt_q + 32'd1;
    assign in_tol     = (measured >= LO) && (measured <= HI);
    assign timed_out  = cnt_q >= TIMEOUT;
    // No prior edge to measure from after reset or loss.
    assign first_edge = (state_q == IDLE) || (state_q == LOST);

    // An edge always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            IDLE: begin
                if (any_edge) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end else if (timed_out) begin
                    state_d = LOST;
                end
            end
            ACQUIRE: begin
                if (any_edge) begin
                    if (!in_tol) begin
                        good_d = '0;
                    end else if (good_q + 32'd1 == LOCK_CNT) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 32'd1;
                    end
                end else if (timed_out) begin
                    state_d = LOST;
                end
            end
            LOCKED: begin
                if (any_edge) begin
                    if (!in_tol) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end else if (timed_out) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (any_edge) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            good_q      <= '0;
            cnt_q       <= '0;
            half_period <= '0;
            tick        <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            tick    <= rise;
            locked  <= (state_d == LOCKED);
            lost    <= (state_d == LOST);
            if (any_edge) begin
                cnt_q <= '0;
                if (!first_edge) begin
                    half_period <= measured;
                end
            end else if (cnt_q != COUNT_MAX) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: table of half-period runs plus reset, tick, loss and timeout-race sequences.
// Drives clk_in on falling clk edges and samples outputs there.
module tb_clock_monitor;

    logic        clk;
    logic        rst;
    logic        clk_in;
    logic        tick;
    logic [31:0] half_period;
    logic        locked;
    logic        lost;

    int n_cmp;
    int n_fail;
    int pend;

    localparam int CHK   = 5;
    localparam int NROWS = 16;

    typedef struct {
        int          h;
        int          n;
        logic [31:0] exp_half;
        logic        exp_locked;
        logic        exp_lost;
    } row_t;

    row_t rows [NROWS];

    clock_monitor #(
        .FROM_HZ     (10),
        .TO_HZ       (1),
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_in      (clk_in),
        .tick        (tick),
        .half_period (half_period),
        .locked      (locked),
        .lost        (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_tick"}, tick, 1'b0);
        chk32({tag, "_half"}, half_period, 32'd0);
        chk1({tag, "_locked"}, locked, 1'b0);
        chk1({tag, "_lost"}, lost, 1'b0);
    endtask

    // n toggles of clk_in, each h cycles after the previous one,
    // then CHK cycles for the last edge to reach the outputs.
    task automatic run(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (h - pend) @(negedge clk);
            clk_in = ~clk_in;
            pend = 0;
        end
        repeat (CHK) @(negedge clk);
        pend = CHK;
    endtask

    // From LOCKED, stop clk_in: lost rises when the counter hits 22,
    // then a fresh edge leaves LOST without touching half_period.
    task automatic lost_seq();
        for (int t = CHK + 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 25) begin
                chk1("pre_timeout_lost", lost, 1'b0);
                chk1("pre_timeout_locked", locked, 1'b1);
            end
            if (t == 26) begin
                chk1("timeout_lost", lost, 1'b1);
                chk1("timeout_locked", locked, 1'b0);
                chk32("timeout_half", half_period, 32'd11);
            end
        end
        @(negedge clk);
        clk_in = ~clk_in;
        for (int u = 1; u <= CHK; u++) begin
            @(negedge clk);
            if (u <= 4) chk1("lost_state_tick", tick, (u == 3) ? clk_in : 1'b0);
            if (u == CHK) begin
                chk1("relost_lost", lost, 1'b0);
                chk1("relost_locked", locked, 1'b0);
                chk32("relost_half", half_period, 32'd11);
            end
        end
        pend = CHK;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        pend   = 0;

        rows[0]  = '{11, 3, 32'd11, 1'b0, 1'b0};
        rows[1]  = '{11, 1, 32'd11, 1'b1, 1'b0};
        rows[2]  = '{14, 1, 32'd14, 1'b0, 1'b0};
        rows[3]  = '{11, 3, 32'd11, 1'b0, 1'b0};
        rows[4]  = '{11, 1, 32'd11, 1'b1, 1'b0};
        rows[5]  = '{ 8, 1, 32'd8,  1'b0, 1'b0};
        rows[6]  = '{ 9, 4, 32'd9,  1'b1, 1'b0};
        rows[7]  = '{ 8, 6, 32'd8,  1'b0, 1'b0};
        rows[8]  = '{13, 3, 32'd13, 1'b0, 1'b0};
        rows[9]  = '{13, 1, 32'd13, 1'b1, 1'b0};
        rows[10] = '{ 8, 1, 32'd8,  1'b0, 1'b0};
        rows[11] = '{11, 4, 32'd11, 1'b1, 1'b0};
        rows[12] = '{11, 4, 32'd11, 1'b1, 1'b0};
        rows[13] = '{22, 1, 32'd22, 1'b0, 1'b0};
        rows[14] = '{23, 1, 32'd23, 1'b0, 1'b0};
        rows[15] = '{11, 4, 32'd11, 1'b1, 1'b0};

        rst    = 1'b1;
        clk_in = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 3 == 0) clk_in = ~clk_in;
            chk_all_zero("in_reset");
        end
        clk_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_all_zero("post_reset");
        end

        repeat (3) @(negedge clk);
        clk_in = 1'b1;
        for (int u = 1; u <= 4; u++) begin
            @(negedge clk);
            chk1("first_tick", tick, (u == 3));
            chk32("first_edge_half", half_period, 32'd0);
        end
        pend = 4;

        for (int r = 0; r < NROWS; r++) begin
            run(rows[r].h, rows[r].n);
            chk32($sformatf("row%0d_half", r), half_period, rows[r].exp_half);
            chk1($sformatf("row%0d_locked", r), locked, rows[r].exp_locked);
            chk1($sformatf("row%0d_lost", r), lost, rows[r].exp_lost);
            if (r == 11) lost_seq();
        end

        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        chk_all_zero("reset_held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
